// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the MIPS system execution controller.
// State encoding is visible on CTRL_state, so the values are fixed.
package sys_ctrl_pkg;

    localparam int CTRL_STATE_W = 2;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_HALT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/sys_debounce.sv
// Step button conditioning: 2-FF synchronizer, stable-count debouncer
// and a registered one-cycle pulse on each debounced rising edge.
module sys_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        prev_d = level_q;
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sys_run_ctrl.sv
// Execution controller: gates the core with a one-cycle CPU_en pulse in
// halt, single-step, divided free-run and PC breakpoint modes.
module sys_run_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int RUN_DIV    = 4,
    parameter int PC_W       = 8
) (
    input  logic                    clk,
    input  logic                    SYS_reset,
    input  logic                    SYS_step_btn,
    input  logic                    SYS_run_sw,
    input  logic                    SYS_bp_en,
    input  logic [PC_W-1:0]         SYS_bp_addr,
    input  logic [PC_W-1:0]         PC,
    input  logic                    cpu_halt,
    output logic                    CPU_en,
    output logic                    CLK_led,
    output logic [CTRL_STATE_W-1:0] CTRL_state,
    output logic [15:0]             step_count
);

    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    ctrl_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             moved_q, moved_d;
    logic             led_q, led_d;
    logic [15:0]      step_count_q, step_count_d;
    logic             run_s1_q, run_s2_q;
    logic             step_req;
    logic             bp_hit;
    logic             cpu_en;

    sys_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk    (clk),
        .rst_n  (SYS_reset),
        .btn_i  (SYS_step_btn),
        .rise_o (step_req)
    );

    // moved_q lets RUN leave a PC that already equals the breakpoint.
    assign bp_hit = moved_q & SYS_bp_en & (PC == SYS_bp_addr);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        moved_d = moved_q;
        cpu_en  = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (cpu_halt) begin
                    state_d = ST_HALT;
                end else if (run_s2_q) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end
            ST_RUN: begin
                if (cpu_halt || !run_s2_q) begin
                    state_d = ST_HALT;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                end else if (div_q == DIV_LAST) begin
                    cpu_en  = 1'b1;
                    moved_d = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (cpu_halt || !run_s2_q) begin
                    state_d = ST_HALT;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
        endcase
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            div_d   = '0;
            moved_d = 1'b0;
        end
        led_d        = led_q ^ cpu_en;
        step_count_d = step_count_q + {15'd0, cpu_en};
    end

    always_ff @(posedge clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q      <= ST_HALT;
            div_q        <= '0;
            moved_q      <= 1'b0;
            led_q        <= 1'b0;
            step_count_q <= '0;
            run_s1_q     <= 1'b0;
            run_s2_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            moved_q      <= moved_d;
            led_q        <= led_d;
            step_count_q <= step_count_d;
            run_s1_q     <= SYS_run_sw;
            run_s2_q     <= run_s1_q;
        end
    end

    assign CPU_en     = cpu_en;
    assign CLK_led    = led_q;
    assign CTRL_state = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_sys_run_ctrl.sv
// Bench for sys_run_ctrl: behavioural model checked every cycle,
// phase table, directed corner sequences and a random phase.
module tb_sys_run_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 4;
    localparam int PW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn, run, bp_en, halt;
    logic [PW-1:0] bp_addr, pc;
    logic          cpu_en, led;
    logic [1:0]    st;
    logic [15:0]   cnt;

    always #5 clk = ~clk;

    sys_run_ctrl #(
        .DEB_CYCLES (DEB),
        .RUN_DIV    (DIV),
        .PC_W       (PW)
    ) dut (
        .clk          (clk),
        .SYS_reset    (rst_n),
        .SYS_step_btn (btn),
        .SYS_run_sw   (run),
        .SYS_bp_en    (bp_en),
        .SYS_bp_addr  (bp_addr),
        .PC           (pc),
        .cpu_halt     (halt),
        .CPU_en       (cpu_en),
        .CLK_led      (led),
        .CTRL_state   (st),
        .step_count   (cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: inputs seen through delay lines, debounce from sample
    // history, RUN timing from cycles elapsed since entering RUN.
    bit          m_b1, m_b2, m_r1, m_r2;
    bit          m_deb, m_rose, m_req;
    bit          hist[$];
    int          m_st;
    int          m_rc;
    bit          m_led;
    logic [15:0] m_cnt;
    bit          s_en;

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_r1 = 0; m_r2 = 0;
        m_deb = 0; m_rose = 0; m_req = 0;
        hist.delete();
        m_st = 0; m_rc = 0; m_led = 0; m_cnt = 16'd0;
    endtask

    function automatic bit m_hit();
        return (m_rc >= DIV) && bp_en && (pc == bp_addr);
    endfunction

    function automatic bit m_en();
        if (m_st == 1) return 1'b1;
        if (m_st == 2)
            return !halt && m_r2 && !m_hit() && (m_rc % DIV == DIV - 1);
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit en, old_b2, all_diff;
        int nst;
        en = m_en();
        case (m_st)
            0: nst = halt ? 0 : m_r2 ? 2 : m_req ? 1 : 0;
            1: nst = 0;
            2: nst = (halt || !m_r2) ? 0 : m_hit() ? 3 : 2;
            default: nst = (halt || !m_r2) ? 0 : m_req ? 1 : 3;
        endcase
        m_rc = (nst == 2 && m_st != 2) ? 0 : m_rc + 1;
        if (en) begin
            m_led = !m_led;
            m_cnt = m_cnt + 16'd1;
            pc = pc + 8'd4;
        end
        old_b2 = m_b2;
        m_req = m_rose;
        m_b2 = m_b1; m_b1 = btn;
        m_r2 = m_r1; m_r1 = run;
        hist.push_back(old_b2);
        if (hist.size() > DEB) void'(hist.pop_front());
        all_diff = (hist.size() == DEB);
        foreach (hist[k]) if (hist[k] == m_deb) all_diff = 0;
        m_rose = 0;
        if (all_diff) begin
            m_rose = !m_deb;
            m_deb = !m_deb;
            hist.delete();
        end
        m_st = nst;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        s_en = cpu_en;
        chk({tag, " en"}, {31'd0, cpu_en}, {31'd0, m_en()});
        chk({tag, " state"}, {30'd0, st}, m_st);
        chk({tag, " count"}, {16'd0, cnt}, {16'd0, m_cnt});
        chk({tag, " led"}, {31'd0, led}, {31'd0, m_led});
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic wait_state(input int s, input int maxc, input string tag);
        int n = 0;
        while (st != 2'(s) && n < maxc) begin
            cycle(tag);
            n++;
        end
        chk({tag, " reached"}, {30'd0, st}, s);
    endtask

    typedef struct {
        bit         run;
        bit         halt;
        int         n;
        logic [1:0] st;
    } vec_t;

    vec_t tv[8];

    initial begin
        int n, first, c0, t_prev;
        bit l0;
        int ts[$];

        tv[0] = '{0, 0, 6, 2'd0};
        tv[1] = '{1, 1, 6, 2'd0};
        tv[2] = '{1, 0, 6, 2'd2};
        tv[3] = '{1, 1, 3, 2'd0};
        tv[4] = '{0, 0, 6, 2'd0};
        tv[5] = '{1, 0, 2, 2'd0};
        tv[6] = '{1, 0, 1, 2'd2};
        tv[7] = '{0, 0, 8, 2'd0};

        rst_n = 1; btn = 0; run = 0; bp_en = 0; halt = 0;
        bp_addr = '0; pc = '0;
        model_reset();
        #1 rst_n = 0;
        #2;
        chk("reset en", {31'd0, cpu_en}, 0);
        chk("reset state", {30'd0, st}, 0);
        chk("reset count", {16'd0, cnt}, 0);
        chk("reset led", {31'd0, led}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        repeat (20) cycle("idle");

        foreach (tv[i]) begin
            run = tv[i].run;
            halt = tv[i].halt;
            repeat (tv[i].n) cycle("tbl");
            chk($sformatf("tbl row%0d state", i), {30'd0, st}, {30'd0, tv[i].st});
        end
        run = 0; halt = 0;

        foreach (tv[i]) begin
            btn = (i % 4) < 2;
            cycle("bounce");
        end
        c0 = cnt; l0 = led;
        btn = 1; n = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle("step");
            if (s_en) begin
                n++;
                if (first < 0) first = i;
            end
        end
        chk("step pulses", n, 1);
        chk("step latency", first, DEB + 4);
        btn = 0;
        repeat (12) cycle("step rel");
        chk("step count", {16'd0, cnt}, {16'd0, 16'(c0 + 1)});
        chk("step led", {31'd0, led}, {31'd0, !l0});

        run = 1;
        for (int i = 0; i < 40; i++) begin
            cycle("run");
            if (s_en) ts.push_back(i);
        end
        chk("run pulse count ok", (ts.size() >= 9 && ts.size() <= 11), 1);
        t_prev = -1;
        foreach (ts[k]) begin
            if (t_prev >= 0) chk("run gap", ts[k] - t_prev, DIV);
            t_prev = ts[k];
        end
        run = 0;
        repeat (3) cycle("run off");
        c0 = cnt;
        repeat (10) cycle("run off");
        chk("run off count", {16'd0, cnt}, c0);
        chk("run off state", {30'd0, st}, 0);

        pc = 8'h00; bp_en = 1; bp_addr = 8'h0C; c0 = cnt;
        run = 1;
        wait_state(3, 60, "bp");
        chk("bp pc", {24'd0, pc}, 32'h0C);
        chk("bp count", {16'd0, cnt}, {16'd0, 16'(c0 + 3)});
        btn = 1; n = 0;
        while (pc != 8'h10 && n < 40) begin
            cycle("bp step");
            n++;
        end
        chk("bp step pc", {24'd0, pc}, 32'h10);
        chk("bp step halt", {30'd0, st}, 0);
        cycle("bp resume");
        chk("bp resume run", {30'd0, st}, 2);
        btn = 0;
        n = 0;
        s_en = 0;
        while (!s_en && n < 10) begin
            cycle("hbp wait");
            n++;
        end
        bp_addr = pc + 8'd4;
        n = 0;
        while (pc != bp_addr && n < 10) begin
            cycle("hbp wait");
            n++;
        end
        halt = 1;
        cycle("hbp");
        chk("halt beats bp", {30'd0, st}, 0);
        run = 0; c0 = cnt;
        btn = 1; repeat (12) cycle("halt btn");
        btn = 0; repeat (12) cycle("halt btn");
        chk("halt step ignored", {16'd0, cnt}, c0);
        chk("halt stays", {30'd0, st}, 0);
        halt = 0; bp_en = 0;
        repeat (4) cycle("settle");

        m_cnt = 16'hFFFF;
        force dut.step_count_q = 16'hFFFF;
        cycle("wrap pre");
        release dut.step_count_q;
        btn = 1; repeat (12) cycle("wrap");
        btn = 0; repeat (12) cycle("wrap");
        chk("wrap count", {16'd0, cnt}, 0);

        btn = 1;
        wait_state(1, 30, "rst step");
        chk("rst step en", {31'd0, cpu_en}, 1);
        #2 rst_n = 0;
        #1;
        chk("rst en drop", {31'd0, cpu_en}, 0);
        chk("rst state", {30'd0, st}, 0);
        chk("rst count", {16'd0, cnt}, 0);
        btn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (10) cycle("post rst");

        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 30 == 0) btn = ~btn;
            if ($urandom % 200 == 0) run = ~run;
            if ($urandom % 150 == 0) halt = ~halt;
            if ($urandom % 100 == 0) bp_en = ~bp_en;
            if ($urandom % 40 == 0) bp_addr = pc + 8'(4 * ($urandom % 3));
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_run_ctrl.md
# sys_run_ctrl

Execution controller for the MIPS `system`: decides when the processor datapath advances one instruction. It gates the core with a single-cycle clock-enable pulse, `CPU_en`, and supports four behaviours: halted, single-step from a debounced push-button, free-run at a divided rate, and a PC-match breakpoint. It sits between the board inputs and the core's state-update enables, and also drives `CLK_led` plus a retired-instruction counter for the LED display mux.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synced samples needed to change the debounced step level. Use ≥1.
- `RUN_DIV`, default 4: cycles between `CPU_en` pulses in RUN. Use ≥2.
- `PC_W`, default 8: width of the PC compare.
- `clk`  in  1  system clock; everything is on its rising edge.
- `SYS_reset`  in  1  asynchronous, active-low reset.
- `SYS_step_btn`  in  1  raw step push-button (async, bouncy).
- `SYS_run_sw`  in  1  raw run switch (async, level).
- `SYS_bp_en`  in  1  breakpoint enable (sync).
- `SYS_bp_addr`  in  PC_W  breakpoint PC (sync).
- `PC`  in  PC_W  current core PC (sync).
- `cpu_halt`  in  1  core fatal/halt request, e.g. invalid opcode (sync, level).
- `CPU_en`  out  1  one-cycle advance pulse to the core.
- `CLK_led`  out  1  toggles on every `CPU_en`.
- `CTRL_state`  out  2  current FSM state.
- `step_count`  out  16  number of `CPU_en` pulses, wraps.

## Operation
- Input conditioning:
  - `SYS_step_btn` and `SYS_run_sw` each pass through a 2-FF synchronizer.
  - The synced step level then passes through the debouncer: the debounced level flips only after the synced input differs from it for `DEB_CYCLES` consecutive cycles. Any agreement restarts the count.
  - `step_req` is a registered one-cycle pulse on each debounced rising edge.
- FSM states: HALT=0, STEP=1, RUN=2, BREAK=3.
  - HALT: `CPU_en`=0.
    - `cpu_halt` → stay in HALT.
    - else synced run=1 → RUN.
    - else `step_req` → STEP.
  - STEP: `CPU_en`=1 for exactly this cycle, then HALT unconditionally.
  - RUN: divider counts 0..RUN_DIV-1 and is cleared on entry. Evaluate in priority order:
    1. `cpu_halt` → HALT.
    2. Synced run=0 → HALT.
    3. Breakpoint hit (`moved`=1, `SYS_bp_en`=1, `PC`==`SYS_bp_addr`) → BREAK.
    4. Otherwise, when div==RUN_DIV-1, `CPU_en`=1.
    - Cases 1–3 suppress `CPU_en` in that cycle.
  - `moved`: cleared on entering RUN, set by the first `CPU_en` in RUN. This lets RUN resume from a PC that equals the breakpoint.
  - BREAK: `CPU_en`=0.
    - `cpu_halt` or synced run=0 → HALT.
    - else `step_req` → STEP.
- `CPU_en` is combinational from state, divider and synchronous inputs.
- On each `CPU_en`:
  - `CLK_led` inverts.
  - `step_count` increments; 16'hFFFF wraps to 0.
- `step_req` pulses are dropped in RUN and STEP; they are not queued.

## Timing
- Reset values:
  - state = HALT; `CTRL_state` = 0.
  - `CPU_en` = 0; `CLK_led` = 0; `step_count` = 0.
  - divider = 0; `moved` = 0; synchronizers = 0; debounced level = 0; debounce counter = 0.
- Reset assertion mid-RUN or mid-STEP takes effect immediately, asynchronously. No `CPU_en` is produced until after release.
- Step latency, taking edge 0 as the first edge sampling the button high with no bounce:
  - debounced level rises at edge DEB_CYCLES+1;
  - `step_req` is registered at edge DEB_CYCLES+2;
  - STEP is entered at edge DEB_CYCLES+3;
  - `CPU_en` is high in the following cycle.
- Run entry: state = RUN two edges after the switch is first sampled high, plus one FSM edge. The first `CPU_en` comes RUN_DIV cycles after entry; later pulses come every RUN_DIV cycles.
- Simultaneous `cpu_halt` and a breakpoint hit: HALT wins.
- Breakpoint hit on the same cycle the divider reaches RUN_DIV-1: BREAK wins, no pulse.

## Structure
- Package `sys_ctrl_pkg`: state encoding constants and `CTRL_state` width.
- Sub-module `sys_debounce`: 2-FF synchronizer, stable counter and rising-edge pulse; parameter `DEB_CYCLES`.
- Run-switch synchronization stays inline.

## Test plan
- Reset, then idle 20 cycles → `CPU_en` never 1, `CTRL_state`=0, `step_count`=0, `CLK_led`=0.
- `DEB_CYCLES`=4, button high with 2-cycle bounces, then stable → exactly one `CPU_en`, at the stated latency after the stable edge; `step_count`=1, `CLK_led`=1.
- Run switch high for 40 cycles, `RUN_DIV`=4 → 10±1 pulses, all exactly 4 cycles apart; switch low → HALT, no further pulses.
- `SYS_bp_en`=1, `SYS_bp_addr`=8'h0C, PC +4 per pulse from 0 → BREAK when PC=0C with no pulse that cycle; one step → PC=10, HALT; switch still high → RUN resumes.
- `cpu_halt` asserted in RUN together with a breakpoint hit → HALT, `CPU_en`=0; step press while `cpu_halt`=1 → ignored.
- Preload `step_count`=16'hFFFF via 65535 pulses (or force), one step → `step_count`=0; reset asserted during STEP → `CPU_en` drops the same cycle.
